ws2812_chain_drv: RTL

WS2812_CHAIN_DRV -- requirements
Module: ws2812_chain_drv

---
 rtl/ws2812_chain_drv.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/ws2812_chain_drv.sv
// WS2812/SK6812 chain driver: serialises an internal LED_NUM x BIT_W pixel memory onto one wire.
// Latency: first HIGH two cycles after an accepted start; bits and LEDs are back to back; a latch gap ends the frame.
// Backpressure: none. start is ignored while busy and in the done cycle. Writes are always accepted.
module ws2812_chain_drv #(
    parameter int CLK_FRE  = 27_000_000,
    parameter int LED_NUM  = 8,
    parameter int BIT_W    = 24,
    parameter int T1H_NS   = 850,
    parameter int T1L_NS   = 400,
    parameter int T0H_NS   = 400,
    parameter int T0L_NS   = 850,
    parameter int RESET_US = 80,
    localparam int AW      = (LED_NUM > 1) ? $clog2(LED_NUM) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [BIT_W-1:0] wr_data,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             dout
);

    function automatic int ns2cyc(input int t_ns);
        longint c;
        c = (longint'(CLK_FRE) / 1000 * longint'(t_ns) + 500_000) / 1_000_000;
        return (c < 1) ? 1 : int'(c);
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int N1H      = ns2cyc(T1H_NS);
    localparam int N1L      = ns2cyc(T1L_NS);
    localparam int N0H      = ns2cyc(T0H_NS);
    localparam int N0L      = ns2cyc(T0L_NS);
    localparam int NRST_RAW = CLK_FRE / 1_000_000 * RESET_US;
    localparam int NRST     = (NRST_RAW < 1) ? 1 : NRST_RAW;
    localparam int CNT_MAX  = imax(imax(imax(N1H, N1L), imax(N0H, N0L)), NRST);
    localparam int CW       = $clog2(CNT_MAX + 1);
    localparam int BCW      = (BIT_W > 1) ? $clog2(BIT_W) : 1;

    localparam logic [CW-1:0]  C1H    = CW'(N1H - 1);
    localparam logic [CW-1:0]  C1L    = CW'(N1L - 1);
    localparam logic [CW-1:0]  C0H    = CW'(N0H - 1);
    localparam logic [CW-1:0]  C0L    = CW'(N0L - 1);
    localparam logic [CW-1:0]  C_RST  = CW'(NRST - 1);
    localparam logic [BCW-1:0] B_TOP  = BCW'(BIT_W - 1);
    localparam logic [AW-1:0]  A_LAST = AW'(LED_NUM - 1);
    localparam logic [AW:0]    A_LIM  = (AW + 1)'(LED_NUM);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_HIGH  = 3'd2;
    localparam logic [2:0] S_LOW   = 3'd3;
    localparam logic [2:0] S_LATCH = 3'd4;

    logic [2:0]       r_state;
    logic [CW-1:0]    r_cnt;
    logic [BCW-1:0]   r_bit;
    logic [AW-1:0]    r_led;
    logic [BIT_W-1:0] r_shift;
    logic             r_busy;
    logic             r_done;
    logic             r_dout;
    logic [BIT_W-1:0] r_mem [LED_NUM];

    logic             w_last_led;
    logic [AW-1:0]    w_rd_addr;
    logic [BIT_W-1:0] w_rd_dat;
    logic [CW-1:0]    w_ld_cnt;
    logic [CW-1:0]    w_nxt_cnt;

    // Pixel memory has no reset so its contents survive a mid-frame abort.
    always_ff @(posedge clk) begin
        if (wr_en && ({1'b0, wr_addr} < A_LIM)) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // The next LED's word is read during the final LOW cycle of the current LED, so its first HIGH follows with no gap.
    assign w_last_led = (r_led == A_LAST);
    assign w_rd_addr  = (r_state == S_LOW && !w_last_led) ? r_led + AW'(1) : r_led;
    assign w_rd_dat   = r_mem[w_rd_addr];
    assign w_ld_cnt   = w_rd_dat[BIT_W-1] ? C1H : C0H;
    assign w_nxt_cnt  = r_shift[BIT_W-2] ? C1H : C0H;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_led   <= '0;
            r_shift <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_dout  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start && !r_done) begin
                        r_state <= S_LOAD;
                        r_busy  <= 1'b1;
                        r_led   <= '0;
                    end
                end
                S_LOAD: begin
                    r_shift <= w_rd_dat;
                    r_bit   <= B_TOP;
                    r_cnt   <= w_ld_cnt;
                    r_dout  <= 1'b1;
                    r_state <= S_HIGH;
                end
                S_HIGH: begin
                    if (r_cnt == '0) begin
                        r_cnt   <= r_shift[BIT_W-1] ? C1L : C0L;
                        r_dout  <= 1'b0;
                        r_state <= S_LOW;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_LOW: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CW'(1);
                    end else if (r_bit != '0) begin
                        r_shift <= {r_shift[BIT_W-2:0], 1'b0};
                        r_bit   <= r_bit - BCW'(1);
                        r_cnt   <= w_nxt_cnt;
                        r_dout  <= 1'b1;
                        r_state <= S_HIGH;
                    end else if (!w_last_led) begin
                        r_led   <= r_led + AW'(1);
                        r_shift <= w_rd_dat;
                        r_bit   <= B_TOP;
                        r_cnt   <= w_ld_cnt;
                        r_dout  <= 1'b1;
                        r_state <= S_HIGH;
                    end else begin
                        r_cnt   <= C_RST;
                        r_state <= S_LATCH;
                    end
                end
                S_LATCH: begin
                    if (r_cnt == '0) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign dout = r_dout;

endmodule
